// File: rtl/piradip_trigger_pkg.sv
// ------------------------------------------------------------------
// piradip_trigger_pkg: shared types and register map for the sequencer
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package piradip_trigger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } trig_state_t;

  localparam logic [11:0] REG_STATUS    = 12'h000;
  localparam logic [11:0] REG_CTRL      = 12'h004;
  localparam logic [11:0] REG_PERIOD    = 12'h008;
  localparam logic [11:0] REG_LOOPS     = 12'h00C;
  localparam logic [11:0] REG_TRIG_BASE = 12'h010;

  localparam int CTRL_GO         = 0;
  localparam int CTRL_ABORT      = 1;
  localparam int CTRL_EXT_ARM    = 2;
  localparam int CTRL_CONTINUOUS = 3;

  // Storage width of a step select; SEL_WIDTH must not exceed this.
  localparam int SEL_MAX_WIDTH = 8;

  typedef struct packed {
    logic                     enable;
    logic                     mode;
    logic [SEL_MAX_WIDTH-1:0] sel;
  } trig_cfg_t;

  function automatic logic [31:0] cfg_to_word(input trig_cfg_t c);
    return {c.enable, 14'b0, c.mode, 8'b0, c.sel};
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi4mm_lite.sv
// ------------------------------------------------------------------
// axi4mm_lite: 32-bit data, 12-bit address AXI4-Lite bundle
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

interface axi4mm_lite;
  logic [11:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [11:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport SUBORDINATE (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport MANAGER (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

`default_nettype wire

// File: rtl/piradip_trigger_timebase.sv
// ------------------------------------------------------------------
// piradip_trigger_timebase: period down-counter, step and loop counters
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module piradip_trigger_timebase #(
  parameter int SEL_WIDTH   = 5,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   run,
  input  logic                   continuous,
  input  logic [COUNT_WIDTH-1:0] period,
  input  logic [COUNT_WIDTH-1:0] loops,
  output logic [SEL_WIDTH-1:0]   step,
  output logic [COUNT_WIDTH-1:0] loops_done,
  output logic                   step_entry,
  output logic                   last_step,
  output logic                   active,
  output logic                   seq_end
);

  logic [COUNT_WIDTH-1:0] cnt;
  logic                   step_end;
  logic                   wrap;

  assign last_step = &step;
  assign step_end  = active && (cnt == '0);
  assign wrap      = continuous || (loops_done < loops);

  // seq_end is registered so the last step's trigger output is still
  // presented while the FSM is in RUN.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      step       <= '0;
      loops_done <= '0;
      cnt        <= '0;
      step_entry <= 1'b0;
      active     <= 1'b0;
      seq_end    <= 1'b0;
    end else begin
      step_entry <= 1'b0;
      seq_end    <= 1'b0;
      if (start) begin
        step       <= '0;
        loops_done <= '0;
        cnt        <= period;
        step_entry <= 1'b1;
        active     <= 1'b1;
      end else if (!run) begin
        active <= 1'b0;
      end else if (step_end) begin
        if (!last_step || wrap) begin
          step       <= step + 1'b1;
          cnt        <= period;
          step_entry <= 1'b1;
          if (last_step && (loops_done != '1)) begin
            loops_done <= loops_done + 1'b1;
          end
        end else begin
          active  <= 1'b0;
          seq_end <= 1'b1;
        end
      end else if (active) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/piradip_trigger_sequencer.sv
// ------------------------------------------------------------------
// piradip_trigger_sequencer: AXI-Lite register file, FSM, trigger compare
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module piradip_trigger_sequencer
  import piradip_trigger_pkg::*;
#(
  parameter int NUM_TRIGGERS = 32,
  parameter int SEL_WIDTH    = 5,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  axi4mm_lite.SUBORDINATE         axilite,
  input  logic                    ext_trig,
  output logic [NUM_TRIGGERS-1:0] triggers,
  output logic                    done,
  output logic                    busy
);

  localparam int TRIG_BASE_WORD = int'(REG_TRIG_BASE >> 2);

  trig_state_t state, state_nxt;

  logic [9:0]             wr_word, rd_word;
  logic                   wr_hs, rd_hs, ctrl_wr, go_req, abort_req, go_accept;
  logic                   bvalid_q, rvalid_q, ext_prev, ext_rise, cont_run;
  logic [31:0]            rdata_q, rd_data_nxt, status_word;
  logic [COUNT_WIDTH-1:0] period_reg, loops_reg, period_run, loops_run, period_tb;
  logic [SEL_WIDTH-1:0]   step;
  logic [COUNT_WIDTH-1:0] loops_done;
  logic                   step_entry, last_step, active, seq_end;
  logic                   tb_start, tb_run, run_gate;
  logic [NUM_TRIGGERS-1:0] fire;
  trig_cfg_t              cfg     [NUM_TRIGGERS];
  trig_cfg_t              cfg_act [NUM_TRIGGERS];
  trig_cfg_t              cfg_eff [NUM_TRIGGERS];
  logic                   unused_bits;

  assign wr_word = axilite.awaddr[11:2];
  assign rd_word = axilite.araddr[11:2];
  assign wr_hs   = axilite.awvalid && axilite.wvalid && !bvalid_q;
  assign rd_hs   = axilite.arvalid && !rvalid_q;

  assign axilite.awready = wr_hs;
  assign axilite.wready  = wr_hs;
  assign axilite.bvalid  = bvalid_q;
  assign axilite.bresp   = 2'b00;
  assign axilite.arready = !rvalid_q;
  assign axilite.rvalid  = rvalid_q;
  assign axilite.rdata   = rdata_q;
  assign axilite.rresp   = 2'b00;

  assign ctrl_wr   = wr_hs && (wr_word == REG_CTRL[11:2]);
  assign abort_req = ctrl_wr && axilite.wdata[CTRL_ABORT];
  assign go_req    = ctrl_wr && axilite.wdata[CTRL_GO] && !axilite.wdata[CTRL_ABORT];
  assign go_accept = go_req && (state == ST_IDLE);
  assign ext_rise  = ext_trig && !ext_prev;

  assign unused_bits = ^{axilite.wdata, axilite.wstrb, axilite.awaddr[1:0], axilite.araddr[1:0]};

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (go_accept) state_nxt = axilite.wdata[CTRL_EXT_ARM] ? ST_ARMED : ST_RUN;
      ST_ARMED: if (abort_req) state_nxt = ST_DONE;
                else if (ext_rise) state_nxt = ST_RUN;
      ST_RUN:   if (abort_req || seq_end) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  assign done     = (state == ST_DONE);
  assign busy     = (state == ST_ARMED) || (state == ST_RUN);
  assign tb_run   = (state_nxt == ST_RUN);
  assign tb_start = tb_run && (state != ST_RUN);
  assign run_gate = tb_run && active;
  // A direct IDLE->RUN start loads the period being sampled this cycle.
  assign period_tb = go_accept ? period_reg : period_run;

  piradip_trigger_timebase #(
    .SEL_WIDTH   (SEL_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_timebase (
    .clk        (clk),
    .resetn     (resetn),
    .start      (tb_start),
    .run        (tb_run),
    .continuous (cont_run),
    .period     (period_tb),
    .loops      (loops_run),
    .step       (step),
    .loops_done (loops_done),
    .step_entry (step_entry),
    .last_step  (last_step),
    .active     (active),
    .seq_end    (seq_end)
  );

  // Channel config is captured at each step entry so mid-step writes wait.
  for (genvar i = 0; i < NUM_TRIGGERS; i++) begin : g_chan
    assign cfg_eff[i] = step_entry ? cfg[i] : cfg_act[i];
    assign fire[i]    = run_gate && cfg_eff[i].enable &&
                        (cfg_eff[i].sel == SEL_MAX_WIDTH'(step)) &&
                        (cfg_eff[i].mode || step_entry);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      triggers <= '0;
      for (int i = 0; i < NUM_TRIGGERS; i++) cfg_act[i] <= '0;
    end else begin
      triggers <= fire;
      for (int i = 0; i < NUM_TRIGGERS; i++) cfg_act[i] <= cfg_eff[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      period_reg <= '0;
      loops_reg  <= '0;
      period_run <= '0;
      loops_run  <= '0;
      cont_run   <= 1'b0;
      ext_prev   <= 1'b0;
      bvalid_q   <= 1'b0;
      for (int i = 0; i < NUM_TRIGGERS; i++) cfg[i] <= '0;
    end else begin
      ext_prev <= ext_trig;
      if (wr_hs)                     bvalid_q <= 1'b1;
      else if (axilite.bready)       bvalid_q <= 1'b0;
      if (wr_hs && wr_word == REG_PERIOD[11:2]) period_reg <= axilite.wdata[COUNT_WIDTH-1:0];
      if (wr_hs && wr_word == REG_LOOPS[11:2])  loops_reg  <= axilite.wdata[COUNT_WIDTH-1:0];
      for (int i = 0; i < NUM_TRIGGERS; i++) begin
        if (wr_hs && wr_word == 10'(TRIG_BASE_WORD + i)) begin
          cfg[i].enable <= axilite.wdata[31];
          cfg[i].mode   <= axilite.wdata[16];
          cfg[i].sel    <= SEL_MAX_WIDTH'(axilite.wdata[SEL_WIDTH-1:0]);
        end
      end
      if (go_accept) begin
        period_run <= period_reg;
        loops_run  <= loops_reg;
        cont_run   <= axilite.wdata[CTRL_CONTINUOUS];
      end
    end
  end

  always_comb begin
    status_word        = '0;
    status_word[1:0]   = state;
    status_word[8 +: SEL_WIDTH] = step;
    status_word[31:16] = 16'(loops_done);
  end

  always_comb begin
    rd_data_nxt = '0;
    if (rd_word == REG_STATUS[11:2])      rd_data_nxt = status_word;
    else if (rd_word == REG_PERIOD[11:2]) rd_data_nxt = 32'(period_reg);
    else if (rd_word == REG_LOOPS[11:2])  rd_data_nxt = 32'(loops_reg);
    else begin
      for (int i = 0; i < NUM_TRIGGERS; i++) begin
        if (rd_word == 10'(TRIG_BASE_WORD + i)) rd_data_nxt = cfg_to_word(cfg[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data_nxt;
      end else if (axilite.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_piradip_trigger_sequencer.sv
// ------------------------------------------------------------------
// tb_piradip_trigger_sequencer: directed bench for the trigger sequencer
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_piradip_trigger_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ext_trig = 1'b0;
  logic [31:0] triggers;
  logic        done;
  logic        busy;
  int          checks = 0;
  int          failures = 0;

  axi4mm_lite bus ();

  piradip_trigger_sequencer #(
    .NUM_TRIGGERS (32),
    .SEL_WIDTH    (5),
    .COUNT_WIDTH  (16)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .axilite  (bus),
    .ext_trig (ext_trig),
    .triggers (triggers),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    bit got = 0;
    @(negedge clk);
    bus.awaddr = a; bus.wdata = d; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    #1;
    for (int n = 0; n < 20; n++) begin
      if (bus.awready) begin got = 1; break; end
      @(negedge clk);
    end
    if (got) @(posedge clk);
    #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL axi_write_timeout addr=%h actual=no_ready required=ready", a);
    end
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
    bit got = 0;
    d = '0;
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1;
    #1;
    for (int n = 0; n < 20; n++) begin
      if (bus.arready) begin got = 1; break; end
      @(negedge clk);
    end
    if (got) begin
      @(posedge clk);
      #1;
      d = bus.rdata;
    end
    bus.arvalid = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL axi_read_timeout addr=%h actual=no_ready required=ready", a);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_t;
    int          k;
    bit          seen;

    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = 4'hF;
    bus.wvalid = 1'b0; bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b1;

    vecs[0]  = '{1'b0, 12'h000, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, 12'h008, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, 12'h00C, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, 12'h010, 32'h0,         32'h0};
    vecs[4]  = '{1'b1, 12'h008, 32'hABCD_0003, 32'h0000_0003};
    vecs[5]  = '{1'b1, 12'h00C, 32'hFFFF_0002, 32'h0000_0002};
    vecs[6]  = '{1'b1, 12'h004, 32'h0000_0003, 32'h0};
    vecs[7]  = '{1'b0, 12'h000, 32'h0,         32'h0};
    vecs[8]  = '{1'b1, 12'h01C, 32'hFFFF_FFFF, 32'h8001_001F};
    vecs[9]  = '{1'b1, 12'h08C, 32'h8000_0011, 32'h8000_0011};
    vecs[10] = '{1'b1, 12'h090, 32'hFFFF_FFFF, 32'h0};
    vecs[11] = '{1'b1, 12'h200, 32'hFFFF_FFFF, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_triggers", triggers, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    for (int v = 0; v < 12; v++) begin
      if (vecs[v].wr) axi_write(vecs[v].addr, vecs[v].wdata);
      axi_read(vecs[v].addr, rd);
      check($sformatf("vec%0d_addr%h", v, vecs[v].addr), rd, vecs[v].exp);
    end
    axi_read(12'h008, rd);
    check("period_after_unmapped", rd, 32'h3);

    // Pulse sweep: one channel per step, single pass, one clock per step.
    axi_write(12'h008, 32'h0);
    axi_write(12'h00C, 32'h0);
    for (int i = 0; i < 32; i++) axi_write(12'(16 + 4 * i), 32'h8000_0000 | i);
    axi_write(12'h004, 32'h1);
    for (int c = 0; c <= 36; c++) begin
      @(negedge clk);
      exp_t = (c >= 1 && c <= 32) ? (32'h1 << (c - 1)) : 32'h0;
      check($sformatf("t1_trig@%0d", c), triggers, exp_t);
      check($sformatf("t1_done@%0d", c), 32'(done), 32'(c == 33));
      check($sformatf("t1_busy@%0d", c), 32'(busy), 32'(c <= 32));
    end

    // Level channel over three passes of 4-clock steps.
    axi_write(12'h008, 32'h3);
    axi_write(12'h00C, 32'h2);
    axi_write(12'h024, 32'h8001_0002);
    axi_write(12'h004, 32'h1);
    for (int c = 0; c <= 390; c++) begin
      @(negedge clk);
      exp_t = {30'b0, 1'(c == 385), 1'(c < 385 && c >= 9 && ((c - 9) % 128) < 4)};
      check($sformatf("t2_done_lvl@%0d", c), {30'b0, done, triggers[5]}, exp_t);
    end
    axi_read(12'h000, rd);
    check("t2_loops_done", {16'b0, rd[31:16]}, 32'h2);
    check("t2_state_idle", {30'b0, rd[1:0]}, 32'h0);

    // External arm.
    axi_write(12'h008, 32'h0);
    axi_write(12'h00C, 32'h0);
    axi_write(12'h004, 32'h5);
    axi_read(12'h000, rd);
    check("t3_state_armed", {30'b0, rd[1:0]}, 32'h1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("t3_armed_quiet@%0d", c), triggers, 32'h0);
    end
    ext_trig = 1'b1;
    @(negedge clk);
    check("t3_run_entry_trig", triggers, 32'h0);
    check("t3_run_entry_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check("t3_step0_pulse", triggers, 32'h1);
    @(negedge clk);
    check("t3_step1_pulse", triggers, 32'h2);
    ext_trig = 1'b0;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("t3_done_seen", 32'(seen), 32'h1);

    // Continuous run, ignored second GO, abort during step 7.
    axi_write(12'h008, 32'h3);
    axi_write(12'h024, 32'h8001_0007);
    axi_write(12'h004, 32'h9);
    repeat (3) @(posedge clk);
    #1;
    axi_write(12'h004, 32'h1);
    repeat (25) @(posedge clk);
    #1;
    check("t4_step7_trig", triggers, 32'h0000_00A0);
    check("t4_busy_before_abort", 32'(busy), 32'h1);
    axi_write(12'h004, 32'h2);
    check("t4_abort_done", 32'(done), 32'h1);
    check("t4_abort_trig", triggers, 32'h0);
    check("t4_abort_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    check("t4_done_one_cycle", 32'(done), 32'h0);
    check("t4_trig_after", triggers, 32'h0);

    // Reset in the middle of a run.
    axi_write(12'h004, 32'h1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("t5_rst_trig", triggers, 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_done", 32'(done), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    k = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done || busy || triggers != 0) k++;
    end
    check("t5_quiet_after_rst", 32'(k), 32'h0);
    axi_read(12'h000, rd);
    check("t5_status", rd, 32'h0);
    axi_read(12'h008, rd);
    check("t5_period", rd, 32'h0);
    axi_read(12'h00C, rd);
    check("t5_loops", rd, 32'h0);
    axi_read(12'h024, rd);
    check("t5_cfg5", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
